// File: rtl/sig_verify_pkg.sv
// Shared constants, state encoding and failure codes for the signature verifier.
// Also holds the helper that extracts a round index from the packed Lc list.
package sig_verify_pkg;

    localparam int T     = 601;
    localparam int NOPEN = 10;
    localparam int LC_W  = 68;
    localparam int LP_W  = 340;
    localparam int IDX_W = 17;
    localparam int CV_W  = 512;
    localparam int K_W   = $clog2(NOPEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ROUND,
        ST_ROOT,
        ST_HCP,
        ST_DONE
    } state_e;

    localparam logic [2:0] FC_OK      = 3'd0;
    localparam logic [2:0] FC_BAD_IDX = 3'd1;
    localparam logic [2:0] FC_ORDER   = 3'd2;
    localparam logic [2:0] FC_ROOT    = 3'd3;
    localparam logic [2:0] FC_CHAL    = 3'd4;
    localparam logic [2:0] FC_TIMEOUT = 3'd5;

    // Entry 0 sits in the MSBs; the round index is the low IDX_W bits of an entry.
    function automatic logic [IDX_W-1:0] lc_idx(input logic [NOPEN*LC_W-1:0] lc,
                                                 input logic [K_W-1:0]        k);
        return lc[(NOPEN-1-int'(k))*LC_W +: IDX_W];
    endfunction

endpackage

// File: rtl/sig_verify_wait.sv
// Start/end handshake watchdog shared by the three engines: reports the end
// pulse while a request is active, or a timeout after TIMEOUT idle wait cycles.
module sig_verify_wait #(
    parameter int TIMEOUT = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic active_i,
    input  logic end_i,
    output logic done_o,
    output logic timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // An end pulse in the cycle the count hits the limit still wins over the timeout.
    always_comb begin
        done_o    = active_i && end_i;
        timeout_o = active_i && !end_i && (cnt_q == LIMIT);
        cnt_d     = '0;
        if (active_i && !end_i && !timeout_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sig_verify.sv
// Verifier controller: range-checks Lc, sequences round/Merkle/challenge engines
// and compares their results against the signature to produce accept/reject.
module sig_verify
    import sig_verify_pkg::*;
#(
    parameter int TIMEOUT = 65535
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    verify_start,
    input  logic [51199:0]          M,
    input  logic [255:0]            salt,
    input  logic [255:0]            pk,
    input  logic [CV_W-1:0]         Cv_root,
    input  logic [NOPEN*LC_W-1:0]   Lc,
    input  logic [LP_W-1:0]         Lp,
    output logic                    rnd_start,
    output logic [IDX_W-1:0]        rnd_idx,
    input  logic                    rnd_end,
    input  logic [CV_W-1:0]         rnd_cv,
    output logic                    mt_start,
    input  logic                    mt_end,
    input  logic [CV_W-1:0]         mt_root,
    output logic                    hcp_start,
    input  logic                    hcp_end,
    input  logic [NOPEN*LC_W-1:0]   hcp_lc,
    input  logic [LP_W-1:0]         hcp_lp,
    output logic [NOPEN*CV_W-1:0]   leaf_bus,
    output logic                    verify_end,
    output logic                    verify_ok,
    output logic [2:0]              fail_code
);

    localparam logic [K_W-1:0] K_LAST = K_W'(NOPEN - 1);

    state_e                  state_q, state_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [IDX_W-1:0]        prev_q, prev_d;
    logic [NOPEN*LC_W-1:0]   lc_q, lc_d;
    logic [LP_W-1:0]         lp_q, lp_d;
    logic [CV_W-1:0]         root_q, root_d;
    logic [NOPEN*CV_W-1:0]   leaf_q, leaf_d;
    logic                    gap_q, gap_d;
    logic [2:0]              fail_q, fail_d;
    logic                    ok_q, ok_d;
    logic                    vend_q, vend_d;

    logic [IDX_W-1:0]        cur_idx;
    logic                    eng_end;
    logic                    w_done;
    logic                    w_timeout;

    // M, salt and pk are consumed by the external engines, not by this controller.
    logic unused_inputs;
    assign unused_inputs = ^{M, salt, pk};

    assign cur_idx = lc_idx(lc_q, k_q);

    // Start requests are decoded from registered state only, so the watchdog
    // feedback into the next-state logic cannot form a combinational loop.
    assign rnd_start = (state_q == ST_ROUND) && !gap_q;
    assign mt_start  = (state_q == ST_ROOT);
    assign hcp_start = (state_q == ST_HCP);
    assign rnd_idx   = (state_q == ST_ROUND) ? cur_idx : '0;

    assign leaf_bus   = leaf_q;
    assign verify_end = vend_q;
    assign verify_ok  = ok_q;
    assign fail_code  = fail_q;

    always_comb begin
        eng_end = 1'b0;
        case (state_q)
            ST_ROUND: eng_end = rnd_end;
            ST_ROOT:  eng_end = mt_end;
            ST_HCP:   eng_end = hcp_end;
            default:  eng_end = 1'b0;
        endcase
    end

    sig_verify_wait #(
        .TIMEOUT (TIMEOUT)
    ) u_wait (
        .clk       (clk),
        .reset     (reset),
        .active_i  (rnd_start | mt_start | hcp_start),
        .end_i     (eng_end),
        .done_o    (w_done),
        .timeout_o (w_timeout)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        prev_d  = prev_q;
        lc_d    = lc_q;
        lp_d    = lp_q;
        root_d  = root_q;
        leaf_d  = leaf_q;
        gap_d   = 1'b0;
        fail_d  = fail_q;
        ok_d    = ok_q;
        vend_d  = vend_q;

        case (state_q)
            ST_IDLE: begin
                if (!verify_start) begin
                    vend_d = 1'b0;
                end else if (!vend_q) begin
                    lc_d    = Lc;
                    lp_d    = Lp;
                    root_d  = Cv_root;
                    fail_d  = FC_OK;
                    ok_d    = 1'b0;
                    k_d     = '0;
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                prev_d = cur_idx;
                k_d    = k_q + 1'b1;
                if (cur_idx >= IDX_W'(T)) begin
                    fail_d  = FC_BAD_IDX;
                    state_d = ST_DONE;
                end else if ((k_q != '0) && (cur_idx <= prev_q)) begin
                    fail_d  = FC_ORDER;
                    state_d = ST_DONE;
                end else if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = ST_ROUND;
                end
            end

            // gap_q forces one idle cycle on rnd_start between consecutive rounds.
            ST_ROUND: begin
                if (w_done) begin
                    leaf_d[(NOPEN-1-int'(k_q))*CV_W +: CV_W] = rnd_cv;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = ST_ROOT;
                    end else begin
                        k_d   = k_q + 1'b1;
                        gap_d = 1'b1;
                    end
                end else if (w_timeout) begin
                    fail_d  = FC_TIMEOUT;
                    state_d = ST_DONE;
                end
            end

            ST_ROOT: begin
                if (w_done) begin
                    if (mt_root != root_q) begin
                        fail_d  = FC_ROOT;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_HCP;
                    end
                end else if (w_timeout) begin
                    fail_d  = FC_TIMEOUT;
                    state_d = ST_DONE;
                end
            end

            ST_HCP: begin
                if (w_done) begin
                    if ((hcp_lc != lc_q) || (hcp_lp != lp_q)) begin
                        fail_d = FC_CHAL;
                    end else begin
                        ok_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end else if (w_timeout) begin
                    fail_d  = FC_TIMEOUT;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                vend_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            prev_q  <= '0;
            lc_q    <= '0;
            lp_q    <= '0;
            root_q  <= '0;
            leaf_q  <= '0;
            gap_q   <= 1'b0;
            fail_q  <= FC_OK;
            ok_q    <= 1'b0;
            vend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            prev_q  <= prev_d;
            lc_q    <= lc_d;
            lp_q    <= lp_d;
            root_q  <= root_d;
            leaf_q  <= leaf_d;
            gap_q   <= gap_d;
            fail_q  <= fail_d;
            ok_q    <= ok_d;
            vend_q  <= vend_d;
        end
    end

endmodule

// File: tb/tb_sig_verify.sv
// Scoreboard bench for sig_verify with behavioural round/Merkle/challenge engines.
module tb_sig_verify;
    import sig_verify_pkg::*;

    localparam int TMO = 16;
    localparam int LAT = 5;
    localparam int MAX_CYC = 2000;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   verify_start = 1'b0;
    logic [51199:0]         M = '0;
    logic [255:0]           salt = '0;
    logic [255:0]           pk = '0;
    logic [CV_W-1:0]        Cv_root = '0;
    logic [NOPEN*LC_W-1:0]  Lc = '0;
    logic [LP_W-1:0]        Lp = '0;
    logic                   rnd_start;
    logic [IDX_W-1:0]       rnd_idx;
    logic                   rnd_end = 1'b0;
    logic [CV_W-1:0]        rnd_cv = '0;
    logic                   mt_start;
    logic                   mt_end = 1'b0;
    logic [CV_W-1:0]        mt_root = '0;
    logic                   hcp_start;
    logic                   hcp_end = 1'b0;
    logic [NOPEN*LC_W-1:0]  hcp_lc = '0;
    logic [LP_W-1:0]        hcp_lp = '0;
    logic [NOPEN*CV_W-1:0]  leaf_bus;
    logic                   verify_end;
    logic                   verify_ok;
    logic [2:0]             fail_code;

    sig_verify #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .verify_start (verify_start),
        .M            (M),
        .salt         (salt),
        .pk           (pk),
        .Cv_root      (Cv_root),
        .Lc           (Lc),
        .Lp           (Lp),
        .rnd_start    (rnd_start),
        .rnd_idx      (rnd_idx),
        .rnd_end      (rnd_end),
        .rnd_cv       (rnd_cv),
        .mt_start     (mt_start),
        .mt_end       (mt_end),
        .mt_root      (mt_root),
        .hcp_start    (hcp_start),
        .hcp_end      (hcp_end),
        .hcp_lc       (hcp_lc),
        .hcp_lp       (hcp_lp),
        .leaf_bus     (leaf_bus),
        .verify_end   (verify_end),
        .verify_ok    (verify_ok),
        .fail_code    (fail_code)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CV_W-1:0] leaf_val(input logic [IDX_W-1:0] idx);
        logic [CV_W-1:0] v;
        for (int i = 0; i < 16; i++)
            v[i*32 +: 32] = (32'(idx) * 32'h9E3779B1) ^ (32'(i) << 20) ^ 32'h5A5A0000;
        return v;
    endfunction

    function automatic logic [CV_W-1:0] root_fold(input logic [NOPEN*CV_W-1:0] bus);
        logic [CV_W-1:0] r;
        r = '0;
        for (int s = 0; s < NOPEN; s++)
            r = {r[CV_W-2:0], r[CV_W-1]} ^ bus[(NOPEN-1-s)*CV_W +: CV_W];
        return r;
    endfunction

    // Engine models: each answers LAT cycles after its request rises.
    logic                  rnd_hang = 1'b0;
    logic [CV_W-1:0]       mt_flip = '0;
    logic [LP_W-1:0]       lp_flip = '0;
    logic [NOPEN*LC_W-1:0] lc_v = '0;
    logic [LP_W-1:0]       lp_v = '0;
    int rnd_cnt = 0;
    int mt_cnt = 0;
    int hcp_cnt = 0;

    always @(negedge clk) begin
        rnd_end = 1'b0;
        mt_end  = 1'b0;
        hcp_end = 1'b0;
        if (rnd_start && !rnd_hang) begin
            rnd_cnt++;
            if (rnd_cnt == LAT) begin
                rnd_end = 1'b1;
                rnd_cv  = leaf_val(rnd_idx);
                rnd_cnt = 0;
            end
        end else rnd_cnt = 0;
        if (mt_start) begin
            mt_cnt++;
            if (mt_cnt == LAT) begin
                mt_end  = 1'b1;
                mt_root = root_fold(leaf_bus) ^ mt_flip;
                mt_cnt  = 0;
            end
        end else mt_cnt = 0;
        if (hcp_start) begin
            hcp_cnt++;
            if (hcp_cnt == LAT) begin
                hcp_end = 1'b1;
                hcp_lc  = lc_v;
                hcp_lp  = lp_v ^ lp_flip;
                hcp_cnt = 0;
            end
        end else hcp_cnt = 0;
    end

    // Scoreboard: expected round indices and run results, popped as the DUT produces them.
    typedef struct {
        logic [2:0] fc;
        logic       ok;
        int         n_rnd;
        int         n_mt;
        int         n_hcp;
    } exp_t;

    logic [IDX_W-1:0] exp_idx_q[$];
    exp_t             res_q[$];
    exp_t             r_mon;
    logic prev_rs = 1'b0, prev_ms = 1'b0, prev_hs = 1'b0, prev_ve = 1'b0;
    int seen_rnd = 0, seen_mt = 0, seen_hcp = 0;

    always @(negedge clk) begin
        if (reset) begin
            seen_rnd = 0; seen_mt = 0; seen_hcp = 0;
            prev_rs = 1'b0; prev_ms = 1'b0; prev_hs = 1'b0; prev_ve = 1'b0;
        end else begin
            chk("one_start", 64'($countones({rnd_start, mt_start, hcp_start}) <= 1), 64'd1);
            if (rnd_start && !prev_rs) begin
                seen_rnd++;
                if (exp_idx_q.size() == 0) chk("rnd_unexpected", 64'd1, 64'd0);
                else chk("rnd_idx", 64'(rnd_idx), 64'(exp_idx_q.pop_front()));
            end
            if (mt_start && !prev_ms) seen_mt++;
            if (hcp_start && !prev_hs) seen_hcp++;
            if (verify_end && !prev_ve) begin
                if (res_q.size() == 0) chk("end_unexpected", 64'd1, 64'd0);
                else begin
                    r_mon = res_q.pop_front();
                    chk("fail_code", 64'(fail_code), 64'(r_mon.fc));
                    chk("verify_ok", 64'(verify_ok), 64'(r_mon.ok));
                    chk("n_rnd", 64'(seen_rnd), 64'(r_mon.n_rnd));
                    chk("n_mt", 64'(seen_mt), 64'(r_mon.n_mt));
                    chk("n_hcp", 64'(seen_hcp), 64'(r_mon.n_hcp));
                end
                seen_rnd = 0; seen_mt = 0; seen_hcp = 0;
            end
            prev_rs = rnd_start;
            prev_ms = mt_start;
            prev_hs = hcp_start;
            prev_ve = verify_end;
        end
    end

    logic [IDX_W-1:0] base_idx [NOPEN];
    logic [IDX_W-1:0] run_idx  [NOPEN];

    task automatic load_run(input logic [IDX_W-1:0] idx [NOPEN], input logic [2:0] fc,
                            input logic ok, input int n_rnd, input int n_mt, input int n_hcp);
        logic [NOPEN*CV_W-1:0] bus;
        exp_t e;
        for (int k = 0; k < NOPEN; k++) begin
            lc_v[(NOPEN-1-k)*LC_W +: LC_W] = {51'(32'hC0DE0000 + k * 777), idx[k]};
            bus[(NOPEN-1-k)*CV_W +: CV_W] = leaf_val(idx[k]);
        end
        for (int w = 0; w < LP_W; w += 32)
            lp_v[w +: 20] = 20'($urandom);
        for (int k = 0; k < n_rnd; k++) exp_idx_q.push_back(idx[k]);
        e.fc = fc; e.ok = ok; e.n_rnd = n_rnd; e.n_mt = n_mt; e.n_hcp = n_hcp;
        res_q.push_back(e);
        Lc = lc_v;
        Lp = lp_v;
        Cv_root = root_fold(bus);
        verify_start = 1'b1;
    endtask

    task automatic run(input logic [IDX_W-1:0] idx [NOPEN], input logic [2:0] fc,
                       input logic ok, input int n_rnd, input int n_mt, input int n_hcp);
        int cyc;
        int first;
        logic [NOPEN*CV_W-1:0] exp_bus;
        @(negedge clk);
        load_run(idx, fc, ok, n_rnd, n_mt, n_hcp);
        cyc = 0;
        first = -1;
        while (!verify_end && cyc < MAX_CYC) begin
            @(negedge clk);
            cyc++;
            if (rnd_start && first < 0) first = cyc;
        end
        chk("verify_end_seen", 64'(verify_end), 64'd1);
        if (n_rnd > 0) chk("rnd_latency", 64'(first), 64'(NOPEN + 1));
        if (n_rnd == NOPEN) begin
            for (int k = 0; k < NOPEN; k++) exp_bus[(NOPEN-1-k)*CV_W +: CV_W] = leaf_val(idx[k]);
            chk("leaf_bus", 64'(leaf_bus == exp_bus), 64'd1);
        end
        chk("starts_low_at_end", 64'({rnd_start, mt_start, hcp_start}), 64'd0);
        repeat (3) @(negedge clk);
        chk("end_held", 64'(verify_end), 64'd1);
        verify_start = 1'b0;
        repeat (2) @(negedge clk);
        chk("end_cleared", 64'(verify_end), 64'd0);
    endtask

    initial begin
        base_idx = '{17'd3, 17'd50, 17'd99, 17'd160, 17'd222, 17'd300, 17'd377, 17'd450, 17'd520, 17'd590};
        M    = {1600{32'hA5A50F0F}};
        salt = {8{32'h13572468}};
        pk   = {8{32'hFEEDBEEF}};

        repeat (3) @(negedge clk);
        chk("reset_ctrl", 64'({verify_end, verify_ok, fail_code, rnd_start, mt_start, hcp_start}), 64'd0);
        chk("reset_rnd_idx", 64'(rnd_idx), 64'd0);
        chk("reset_leaf_bus", 64'(leaf_bus == '0), 64'd1);
        reset = 1'b0;

        run(base_idx, FC_OK, 1'b1, NOPEN, 1, 1);

        run_idx = base_idx;
        run_idx[4] = 17'd601;
        run(run_idx, FC_BAD_IDX, 1'b0, 0, 0, 0);

        run_idx = base_idx;
        run_idx[2] = 17'd50;
        run(run_idx, FC_ORDER, 1'b0, 0, 0, 0);

        mt_flip = '0;
        mt_flip[0] = 1'b1;
        run(base_idx, FC_ROOT, 1'b0, NOPEN, 1, 0);
        mt_flip = '0;

        lp_flip = '0;
        lp_flip[7] = 1'b1;
        run(base_idx, FC_CHAL, 1'b0, NOPEN, 1, 1);
        lp_flip = '0;

        rnd_hang = 1'b1;
        run(base_idx, FC_TIMEOUT, 1'b0, 1, 0, 0);
        rnd_hang = 1'b0;

        // Abort mid-ROUND with reset, then a clean run must still be accepted.
        @(negedge clk);
        load_run(base_idx, FC_OK, 1'b1, NOPEN, 1, 1);
        for (int c = 0; c < MAX_CYC && seen_rnd < 3; c++) @(negedge clk);
        chk("reached_round3", 64'(seen_rnd), 64'd3);
        reset = 1'b1;
        verify_start = 1'b0;
        @(negedge clk);
        chk("midrst_ctrl", 64'({verify_end, verify_ok, fail_code, rnd_start, mt_start, hcp_start}), 64'd0);
        chk("midrst_leaf_bus", 64'(leaf_bus == '0), 64'd1);
        exp_idx_q.delete();
        res_q.delete();
        @(negedge clk);
        reset = 1'b0;
        run(base_idx, FC_OK, 1'b1, NOPEN, 1, 1);

        chk("scoreboard_empty", 64'(exp_idx_q.size() + res_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sig_verify.md
Name: sig_verify

Overview:
- Verifier-side controller: the counterpart to the signing top level.
- Accepts a signature (Cv_root, Lc, Lp), the message, the salt and the public key.
- Range-checks the opened round indices, then sequences three external engines over start/end handshakes:
  - round recompute, once per opened round;
  - Merkle root rebuild;
  - challenge hash.
- Compares the recomputed values with the signature and reports accept/reject with a failure code.

Parameters:
- T, 601, total number of parallel rounds
- NOPEN, 10, number of opened/challenged rounds (entries in Lc)
- LC_W, 68, width of one Lc entry; round index is entry[16:0]
- LP_W, 340, total width of Lp
- TIMEOUT, 65535, maximum cycles to wait for any engine's end pulse

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- verify_start  in  1  level request; sampled only in IDLE
- M  in  51200  message
- salt  in  256  salt
- pk  in  256  public key
- Cv_root  in  512  signature Merkle root
- Lc  in  NOPEN*LC_W  challenge list; entry 0 is in the MSBs
- Lp  in  LP_W  challenge list (second part)
- rnd_start  out  1  round engine request (level)
- rnd_idx  out  17  round index being recomputed
- rnd_end  in  1  round engine done; rnd_cv valid while high
- rnd_cv  in  512  recomputed leaf commitment
- mt_start  out  1  Merkle engine request (level)
- mt_end  in  1  Merkle done; mt_root valid while high
- mt_root  in  512  recomputed root
- hcp_start  out  1  challenge engine request (level)
- hcp_end  in  1  challenge done
- hcp_lc  in  NOPEN*LC_W  recomputed Lc
- hcp_lp  in  LP_W  recomputed Lp
- leaf_bus  out  NOPEN*512  collected leaves, for the Merkle/challenge engines
- verify_end  out  1  done; held until verify_start is low
- verify_ok  out  1  accept flag; valid while verify_end is high
- fail_code  out  3  0 ok, 1 bad index, 2 not increasing, 3 root mismatch, 4 challenge mismatch, 5 timeout

Behaviour:
- Reset state: all outputs 0, state IDLE, counters 0, leaf_bus 0. Reset asserted mid-operation aborts immediately; the next run starts from IDLE.
- IDLE:
  - If verify_start=1 and verify_end=0: latch Lc, Lp, Cv_root; clear fail_code and verify_ok; set k=0; go to CHECK next cycle.
  - If verify_start=0: clear verify_end.
- CHECK: one entry per cycle, k=0..NOPEN-1, with idx=entry[16:0].
  - idx>=T: fail_code=1, go to DONE.
  - k>0 and idx<=previous idx: fail_code=2, go to DONE.
  - After k=NOPEN-1 passes: k=0, go to ROUND.
- ROUND:
  - rnd_start=1 and rnd_idx=idx(k), held until rnd_end.
  - In the rnd_end cycle: store rnd_cv into leaf_bus slot k (slot 0 in the MSBs) and drop rnd_start the next cycle.
  - rnd_start stays low for at least one cycle between rounds.
  - After slot NOPEN-1 is stored: go to ROOT.
- ROOT:
  - mt_start=1 until mt_end.
  - On mt_end: mt_root != Cv_root gives fail_code=3 and DONE; otherwise go to HCP.
- HCP:
  - hcp_start=1 until hcp_end.
  - On hcp_end: hcp_lc != Lc or hcp_lp != Lp gives fail_code=4; otherwise verify_ok=1. Go to DONE.
- Timeout:
  - A wait counter resets on entering each wait and increments each cycle that the awaited end pulse is low.
  - At count==TIMEOUT: fail_code=5, drop all start outputs, go to DONE.
  - An end pulse arriving in the same cycle as the count reaching TIMEOUT counts as success.
- DONE: set verify_end=1 one cycle later, then return to IDLE. verify_end stays high until verify_start=0 has been seen in IDLE.
- End pulses received outside their matching wait state are ignored.
- Only one start output is high at any time.
- Latency (no engine stall): the first rnd_start rises NOPEN+1 cycles after verify_start is sampled.

Decomposition:
- Shared package holds:
  - T, NOPEN, LC_W, LP_W;
  - state encodings IDLE, CHECK, ROUND, ROOT, HCP, DONE;
  - fail_code constants.
- One natural sub-module: sig_verify_wait, a start/end handshake with timeout counter. Instantiate it once and multiplex it across the three engines.

Test Plan:
- Valid run: Lc indices 3,50,99,…,590 ascending, engine models return matching values with 5-cycle latency → rnd_idx sequence 3,50,…; verify_ok=1, fail_code=0, verify_end high until start is dropped.
- Bad index: entry 4 idx=601 → DONE after 5 CHECK cycles, fail_code=1, rnd_start never asserted.
- Non-increasing indices: entry 2 equals entry 1 (both 50) → fail_code=2.
- Root mismatch: mt_root with bit 0 flipped → fail_code=3, hcp_start never asserted.
- Challenge mismatch: hcp_lp with bit 7 flipped → fail_code=4, verify_ok=0.
- Timeout and reset:
  - With TIMEOUT=16, the round engine never responds → fail_code=5 after 16 wait cycles, rnd_start dropped.
  - A reset pulse mid-ROUND clears all outputs; a second run then succeeds.
